// File: rtl/dl_frame_sequencer.sv
// Downlink frame sequencer: round-robin arbitration between the ENC0/ENC1 parity buffers, then
// preamble, header and data words into the DL serializer. Optional error injection: DL_SEQ_ERR_INJ_EN.
module dl_frame_sequencer #(
    parameter int                    DATA_WIDTH     = 10,
    parameter int                    ENC0_DEPTH     = 8,
    parameter int                    ENC1_WIDTH     = 6,
    parameter int                    ENC1_DEPTH     = 4,
    parameter int                    PREAMBLE_COUNT = 4,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD  = DATA_WIDTH'(10'h2AA)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dl_enable,
    input  logic                  ch0_frame_rdy,
    output logic                  ch0_rd_en,
    input  logic [DATA_WIDTH-1:0] ch0_rd_data,
    input  logic                  ch1_frame_rdy,
    output logic                  ch1_rd_en,
    input  logic [ENC1_WIDTH-1:0] ch1_rd_data,
    output logic                  ser_valid,
    output logic [DATA_WIDTH-1:0] ser_data,
    input  logic                  ser_ready,
    output logic                  busy,
    output logic                  grant_ch,
    output logic                  frame_done
`ifdef DL_SEQ_ERR_INJ_EN
   ,input  logic                  err_inj_enable,
    input  logic [DATA_WIDTH-1:0] err_inj_mask
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        DATA,
        DONE
    } state_t;

    localparam logic [3:0] ENC0_LEN      = 4'(ENC0_DEPTH);
    localparam logic [3:0] ENC1_LEN      = 4'(ENC1_DEPTH);
    localparam logic [3:0] ENC0_LAST     = 4'(ENC0_DEPTH - 1);
    localparam logic [3:0] ENC1_LAST     = 4'(ENC1_DEPTH - 1);
    localparam logic [3:0] PREAMBLE_LAST = 4'(PREAMBLE_COUNT - 1);

    if (ENC1_WIDTH > DATA_WIDTH) begin : g_bad_enc1_width
        $error("ENC1_WIDTH must not exceed DATA_WIDTH");
    end
    if (ENC0_DEPTH < 1 || ENC0_DEPTH > 15 || ENC1_DEPTH < 1 || ENC1_DEPTH > 15) begin : g_bad_depth
        $error("frame depths must be in 1..15");
    end
    if (PREAMBLE_COUNT < 1 || PREAMBLE_COUNT > 16) begin : g_bad_preamble
        $error("PREAMBLE_COUNT must be in 1..16");
    end

    state_t                state;
    logic [3:0]            word_cnt;
    logic                  load_ok;
    logic                  data_load;
    logic [3:0]            data_last;
    logic [DATA_WIDTH-1:0] header_word;
    logic [DATA_WIDTH-1:0] data_word;

    // The output register may take a new word when it is empty or its word leaves this cycle.
    assign load_ok   = !ser_valid || ser_ready;
    assign data_load = (state == DATA) && load_ok;

    // NOTE: the pop strobes are decoded combinationally so the pop lands in the same cycle the
    // show-ahead head word is captured; a registered strobe would pop one word late.
    assign ch0_rd_en = data_load && !grant_ch;
    assign ch1_rd_en = data_load &&  grant_ch;

    assign data_last   = grant_ch ? ENC1_LAST : ENC0_LAST;
    assign header_word = DATA_WIDTH'({4'b1100, grant_ch, 1'b0, (grant_ch ? ENC1_LEN : ENC0_LEN)});

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_word = grant_ch ? DATA_WIDTH'(ch1_rd_data) : ch0_rd_data;
`ifdef DL_SEQ_ERR_INJ_EN
        if (err_inj_enable) begin
            data_word = data_word ^ err_inj_mask;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_cnt   <= 4'd0;
            ser_valid  <= 1'b0;
            ser_data   <= '0;
            busy       <= 1'b0;
            grant_ch   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // frame_done high means the previous frame ended last edge; wait one more cycle.
                    if (dl_enable && !frame_done && (ch0_frame_rdy || ch1_frame_rdy)) begin
                        if (ch0_frame_rdy && ch1_frame_rdy) begin
                            grant_ch <= !grant_ch;
                        end else begin
                            grant_ch <= ch1_frame_rdy;
                        end
                        busy     <= 1'b1;
                        state    <= PREAMBLE;
                        word_cnt <= 4'd0;
                    end
                end

                PREAMBLE: begin
                    if (load_ok) begin
                        ser_valid <= 1'b1;
                        ser_data  <= PREAMBLE_WORD;
                        if (word_cnt == PREAMBLE_LAST) begin
                            state    <= HEADER;
                            word_cnt <= 4'd0;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end

                HEADER: begin
                    if (load_ok) begin
                        ser_valid <= 1'b1;
                        ser_data  <= header_word;
                        state     <= DATA;
                        word_cnt  <= 4'd0;
                    end
                end

                DATA: begin
                    if (load_ok) begin
                        ser_valid <= 1'b1;
                        ser_data  <= data_word;
                        if (word_cnt == data_last) begin
                            state    <= DONE;
                            word_cnt <= 4'd0;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end

                DONE: begin
                    if (load_ok) begin
                        ser_valid  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        word_cnt   <= 4'd0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    word_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/dl_frame_sequencer.md
Name: dl_frame_sequencer

Overview:
- Downlink controller that shares the single DL serializer between the two CRC-encoder channels: ENC0 (10-bit parallel words, 8 per frame) and ENC1 (6-bit parallel words, 4 per frame).
- Arbitrates frame requests round-robin, emits the DL preamble and a header word, then drains the granted encoder's parity-word buffer into the serializer under valid/ready flow control.
- Sits between the two encoder output buffers and the serializer input in the FEC TX path.

Parameters:
- DATA_WIDTH, 10, serializer word width; equals ENC0 parallel width.
- ENC0_DEPTH, 8, words per ENC0 frame (max 15).
- ENC1_WIDTH, 6, ENC1 parallel word width; must be ≤ DATA_WIDTH.
- ENC1_DEPTH, 4, words per ENC1 frame (max 15).
- PREAMBLE_COUNT, 4, preamble words per frame (≥1).
- PREAMBLE_WORD, 10'h2AA, preamble pattern.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dl_enable  in  1  permits new frame grants
- ch0_frame_rdy  in  1  ENC0 buffer holds a complete frame (level)
- ch0_rd_en  out  1  pop strobe to ENC0 buffer
- ch0_rd_data  in  DATA_WIDTH  ENC0 head word, valid in the ch0_rd_en cycle (show-ahead)
- ch1_frame_rdy  in  1  ENC1 buffer holds a complete frame
- ch1_rd_en  out  1  pop strobe to ENC1 buffer
- ch1_rd_data  in  ENC1_WIDTH  ENC1 head word (show-ahead)
- ser_valid  out  1  word presented to serializer
- ser_data  out  DATA_WIDTH  word to serializer
- ser_ready  in  1  serializer accepts word
- busy  out  1  frame in progress
- grant_ch  out  1  channel of current or last frame
- frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; ser_valid=0, ser_data=0, ch0_rd_en=0, ch1_rd_en=0, busy=0, grant_ch=1, frame_done=0; round-robin pointer set so ch0 wins first.
- Output stage: ser_data/ser_valid are registered. A new word loads when (!ser_valid || ser_ready). Under backpressure, ser_data stays stable until the word is accepted. A transfer is the ser_valid & ser_ready cycle.
- FSM states: IDLE, PREAMBLE, HEADER, DATA, DONE.
- IDLE: if dl_enable and any chX_frame_rdy, grant that channel. If both are ready, grant the channel opposite grant_ch. Go to PREAMBLE; busy=1. First preamble word is valid on the next cycle.
- PREAMBLE: load PREAMBLE_WORD PREAMBLE_COUNT times, then go to HEADER.
- HEADER: load header word {4'b1100, grant_ch, 1'b0, len[3:0]}, where len = ENC0_DEPTH or ENC1_DEPTH. Go to DATA.
- DATA: on each load, assert chX_rd_en for the granted channel for exactly that cycle and register its rd_data. ENC1 data is zero-extended in the MSBs. After DEPTH loads, go to DONE.
- DONE: wait for the last word to be accepted. Then pulse frame_done for one cycle, set busy=0, ser_valid=0, return to IDLE.
- A frame is never granted in the same cycle frame_done is asserted. Minimum idle gap between frames is 1 cycle.
- Total words per frame: PREAMBLE_COUNT + 1 + DEPTH. With ser_ready held at 1, frame_done fires PREAMBLE_COUNT + DEPTH + 3 cycles after the grant cycle.
- A granted frame always completes. Deasserting chX_frame_rdy or dl_enable mid-frame is ignored; dl_enable only gates new grants.
- Only one rd_en is high at a time, never outside DATA, and never while the output register holds an unaccepted word.
- Word counter is 4 bits wide and is cleared on every state entry.
- Reset mid-frame aborts immediately. Encoder buffers are not re-synchronised by this block.

Optional Feature:
- Macro: DL_SEQ_ERR_INJ_EN.
- When defined, adds inputs err_inj_enable (1 bit) and err_inj_mask (DATA_WIDTH bits). In DATA state, when err_inj_enable=1, each loaded word is XORed with err_inj_mask. Preamble and header words are never modified.
- When undefined, these ports and the XOR logic do not exist; data passes unmodified.

Test Plan:
- ch0 single frame, ser_ready=1 → 0x2AA ×4, 0x308, then 8 ch0 words in order. 8 ch0_rd_en pulses. frame_done at grant+15. grant_ch=0.
- ch1 single frame → 0x2AA ×4, 0x324, then 4 words with bits[9:6]=0. frame_done at grant+11.
- Both frame_rdy asserted right after reset → ch0 frame then ch1 frame, at least one idle cycle between them. Hold both ready → strict alternation.
- ser_ready toggled 1/0 every cycle in DATA → ser_data stable while ser_valid&!ser_ready. No words lost or duplicated. rd_en count = DEPTH.
- dl_enable dropped during HEADER → frame completes. No new grant while dl_enable=0 even with frame_rdy=1.
- rst_n asserted in DATA → all outputs 0 asynchronously, grant_ch=1. After release with ch1 ready only → ch1 granted. With DL_SEQ_ERR_INJ_EN, mask 0x001 enabled → every data word LSB flipped; preamble and header unchanged.
